// File: rtl/arith_unit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : arith_unit_scheduler
//  Purpose  : Round-robin scheduler sharing one multi-cycle arithmetic unit
//             among NREQ requesters, with timeout abort and divide-by-zero
//             short-circuit.
//  Revision : 1.0  initial release
// ============================================================================
module arith_unit_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int RW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op_in,
  input  logic [DW*NREQ-1:0] x_in,
  input  logic [DW*NREQ-1:0] y_in,
  output logic [NREQ-1:0]    gnt,
  output logic               unit_start,
  output logic               unit_abort,
  output logic [1:0]         unit_op,
  output logic [DW-1:0]      unit_x,
  output logic [DW-1:0]      unit_y,
  input  logic               unit_done,
  input  logic [RW-1:0]      unit_res,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [RW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cw = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cw-1:0] c_tmax = c_cw'(TIMEOUT - 1);
  localparam logic [1:0] c_op_div = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_pw-1:0]   r_ptr, w_ptr_nxt;
  logic [c_pw-1:0]   r_win, w_win_nxt;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_start, w_start_nxt;
  logic              r_abort, w_abort_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [DW-1:0]     r_x, w_x_nxt;
  logic [DW-1:0]     r_y, w_y_nxt;
  logic [NREQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
  logic [RW-1:0]     r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_busy;

  logic              w_found;
  logic [c_pw-1:0]   w_win;
  logic [1:0]        w_sel_op;
  logic [DW-1:0]     w_sel_x;
  logic [DW-1:0]     w_sel_y;

  function automatic logic [NREQ-1:0] onehot(input logic [c_pw-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin winner: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = c_pw'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_sel_op = op_in[2*w_win +: 2];
  assign w_sel_x  = x_in[DW*w_win +: DW];
  assign w_sel_y  = y_in[DW*w_win +: DW];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_win_nxt       = r_win;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = '0;
    w_start_nxt     = 1'b0;
    w_abort_nxt     = 1'b0;
    w_op_nxt        = r_op;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win_nxt = w_win;
          w_op_nxt  = w_sel_op;
          w_x_nxt   = w_sel_x;
          w_y_nxt   = w_sel_y;
          w_gnt_nxt = onehot(w_win);
          if (w_sel_op == c_op_div && w_sel_y == '0) begin
            // Divide-by-zero: answer directly, grant and response coincide.
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = onehot(w_win);
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
          end else begin
            w_state_nxt = S_ISSUE;
            w_start_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (unit_done) begin
          // Completion takes priority over a simultaneous timeout.
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = onehot(r_win);
          w_rsp_data_nxt  = unit_res;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_cnt == c_tmax) begin
          w_state_nxt     = S_RESP;
          w_abort_nxt     = 1'b1;
          w_rsp_valid_nxt = onehot(r_win);
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = (r_win == c_pw'(NREQ - 1)) ? '0 : r_win + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_op        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_win       <= w_win_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_start     <= w_start_nxt;
      r_abort     <= w_abort_nxt;
      r_op        <= w_op_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign gnt        = r_gnt;
  assign unit_start = r_start;
  assign unit_abort = r_abort;
  assign unit_op    = r_op;
  assign unit_x     = r_x;
  assign unit_y     = r_y;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire
